// File: rtl/axis_rng_range_pkg.sv
// Shared definitions for the Lemire range reducer: state encoding, iteration
// count and the saturating reject-counter helper.
package axis_rng_range_pkg;

    localparam int unsigned ITER_COUNT = 32;
    localparam logic [5:0]  ITER_LAST  = 6'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_MUL  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axis_rng_range_if.sv
// AXI4-Stream style handshake bundle for 32-bit words.
interface axis_rng_range_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/rng_shift_add_mul32.sv
// Iterative 32x32 -> 64 shift-add multiplier: operands captured on start_i,
// one partial product per cycle, done_o pulses when the product is final.
module rng_shift_add_mul32
    import axis_rng_range_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [63:0] product_o
);

    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [5:0]  cnt_q;
    logic        run_q;
    logic        done_q;
    logic [63:0] acc_d;

    // Conditional add of the shifted multiplicand for the current multiplier bit
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Operand capture and iteration sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            cnt_q    <= 6'd0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= 64'd0;
            mcand_q  <= {32'd0, a_i};
            mplier_q <= b_i;
            cnt_q    <= 6'd0;
            run_q    <= 1'b1;
            done_q   <= 1'b0;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 6'd1;
            if (cnt_q == ITER_LAST) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end else begin
                done_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/axis_rng_range.sv
// Unbiased reduction of uniform 32-bit words into [0, N) using Lemire's
// multiply-and-reject method; N = 0 passes words through unchanged.
module axis_rng_range
    import axis_rng_range_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    axis_rng_range_if.slave         input_axis,
    axis_rng_range_if.master        output_axis,
    input  logic [31:0]             range_val,
    input  logic                    range_load,
    output logic                    busy,
    output logic [15:0]             reject_count
);

    state_e      state_q;
    logic [31:0] n_q;
    logic [31:0] t_q;
    logic [31:0] rem_q;
    logic [31:0] dvd_q;
    logic [5:0]  div_cnt_q;
    logic [31:0] tdata_q;
    logic        tvalid_q;
    logic        busy_q;
    logic [15:0] rej_q;

    logic        in_ready_s;
    logic        mul_start_s;
    logic        mul_done_s;
    logic [63:0] mul_product_s;
    logic [32:0] rem_shift_s;
    logic [31:0] rem_d;
    logic        accept_s;

    assign in_ready_s  = (state_q == ST_IDLE) && !range_load;
    assign mul_start_s = in_ready_s && input_axis.tvalid && (n_q != 32'd0);
    assign accept_s    = (mul_product_s[31:0] >= t_q);

    // One restoring-division step; the remainder always fits in 32 bits
    // because it stays below N.
    always_comb begin
        rem_shift_s = {rem_q, dvd_q[31]};
        rem_d       = rem_shift_s[31:0];
        if (rem_shift_s >= {1'b0, n_q}) begin
            rem_d = 32'(rem_shift_s - {1'b0, n_q});
        end else begin
            rem_d = rem_shift_s[31:0];
        end
    end

    rng_shift_add_mul32 u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start_s),
        .a_i       (input_axis.tdata),
        .b_i       (n_q),
        .done_o    (mul_done_s),
        .product_o (mul_product_s)
    );

    // Control FSM with all datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_q       <= 32'd0;
            t_q       <= 32'd0;
            rem_q     <= 32'd0;
            dvd_q     <= 32'd0;
            div_cnt_q <= 6'd0;
            tdata_q   <= 32'd0;
            tvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            rej_q     <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (range_load) begin
                        n_q       <= range_val;
                        rej_q     <= 16'd0;
                        rem_q     <= 32'd0;
                        dvd_q     <= 32'd0 - range_val;
                        div_cnt_q <= 6'd0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_DIV;
                    end else if (input_axis.tvalid) begin
                        if (n_q == 32'd0) begin
                            tdata_q  <= input_axis.tdata;
                            tvalid_q <= 1'b1;
                            state_q  <= ST_OUT;
                        end else begin
                            state_q  <= ST_MUL;
                        end
                    end
                end
                ST_DIV: begin
                    rem_q     <= rem_d;
                    dvd_q     <= dvd_q << 1;
                    div_cnt_q <= div_cnt_q + 6'd1;
                    if (div_cnt_q == ITER_LAST) begin
                        // Divide-by-zero remainder is meaningless; N = 0 never rejects
                        t_q     <= (n_q == 32'd0) ? 32'd0 : rem_d;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        if (accept_s) begin
                            tdata_q  <= mul_product_s[63:32];
                            tvalid_q <= 1'b1;
                            state_q  <= ST_OUT;
                        end else begin
                            rej_q    <= sat_inc16(rej_q);
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_OUT: begin
                    if (output_axis.tready) begin
                        tvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign input_axis.tready  = in_ready_s;
    assign output_axis.tdata  = tdata_q;
    assign output_axis.tvalid = tvalid_q;
    assign busy               = busy_q;
    assign reject_count       = rej_q;

endmodule
